// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_pkg
// Purpose : Shared definitions for the sequential right shifter: default
//           datapath / shift-amount widths and the controller state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package shift_pkg;

  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_right_1.sv
`default_nettype none
// ============================================================================
// Module  : shift_right_1
// Purpose : Combinational one-bit right shift with an explicit fill bit that
//           becomes the new MSB.
// Ports   : a_i    [WIDTH-1:0]  operand
//           fill_i              bit shifted into position WIDTH-1
//           y_o    [WIDTH-1:0]  a_i shifted right by one
// Rev     : 1.0  initial release
// ============================================================================
module shift_right_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = {fill_i, a_i[WIDTH-1:1]};

endmodule : shift_right_1
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module  : shift_right_seq
// Purpose : Multi-cycle right shifter. A start in IDLE captures the operand,
//           shift amount and mode; the operand is then shifted one bit per
//           cycle until the count reaches zero, and the result is presented
//           with a one-cycle done pulse.
// Ports   : clk_i                    rising-edge clock
//           reset_i                  synchronous active-high reset
//           start_i                  request, sampled only in IDLE
//           in_i     [WIDTH-1:0]     operand
//           shamt_i  [SHAMT_W-1:0]   shift amount 0..WIDTH-1
//           arith_i                  1 = sign fill, 0 = zero fill
//           busy_o                   high in SHIFT or DONE
//           done_o                   one-cycle result-valid pulse
//           out_o    [WIDTH-1:0]     result, held until the next DONE
// Rev     : 1.0  initial release
// ============================================================================
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = shift_pkg::WIDTH,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   in_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   out_o
);

  localparam logic [SHAMT_W-1:0] C_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q,  work_d;
  logic [SHAMT_W-1:0]   cnt_q,   cnt_d;
  logic                 fill_q,  fill_d;
  logic [WIDTH-1:0]     out_q,   out_d;
  logic [WIDTH-1:0]     shifted;

  // The fill bit is resolved once at capture time (sign bit for arithmetic,
  // zero for logical) so the shift path never looks at the mode again.
  shift_right_1 #(
    .WIDTH (WIDTH)
  ) u_shift_right_1 (
    .a_i    (work_q),
    .fill_i (fill_q),
    .y_o    (shifted)
  );

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          work_d = in_i;
          cnt_d  = shamt_i;
          fill_d = arith_i & in_i[WIDTH-1];
          if (shamt_i == '0) begin
            state_d = DONE;
            out_d   = in_i;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - C_ONE;
        // The last shift lands directly in DONE and publishes the result on
        // the same edge, so latency equals the shift amount.
        if (cnt_q == C_ONE) begin
          state_d = DONE;
          out_d   = shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state_q == SHIFT) || (state_q == DONE);
    done_o = (state_q == DONE);
    out_o  = out_q;
  end

endmodule : shift_right_seq
`default_nettype wire
